i2c_target: RTL and testbench
=============================

// Module: i2c_target
// PURPOSE
//  I2C target (slave) responder: the far end of the I2C init master, used as an on-chip
//  register target and as the bus model for the init sequencer. Oversamples SCL/SDA on clk
//  and decodes START/STOP. Accepts [addr+W][reg][data..] writes and [addr+R][data..] reads,
//  auto-incrementing an 8-bit register pointer; drives SDA open-drain via sda_oe.
// PARAMETERS
//  SLAVE_ADDR   7'h10  7-bit target address matched after START
//  SYNC_STAGES  2      input synchroniser depth for scl_di/sda_di (>=2)
// PORTS
//  clk       in   1  system clock; all logic on posedge; >=8x SCL rate
//  areset_n  in   1  synchronous active-low reset, sampled on posedge clk
//  scl_di    in   1  SCL pin input (asynchronous)
//  sda_di    in   1  SDA pin input (asynchronous)
//  sda_oe    out  1  1 = pull SDA low, 0 = release (drives the IOBUF T/A pair)
//  wr_en     out  1  one-clk write strobe
//  wr_addr   out  8  register address for wr_en
//  wr_data   out  8  write data for wr_en
//  rd_addr   out  8  current read pointer; held stable while a read byte is fetched
//  rd_data   in   8  register contents at rd_addr; must be valid 1 clk after rd_addr changes
//  rd_strobe out  1  one-clk pulse when rd_data is latched into the TX shifter
//  busy      out  1  1 from START to STOP
// BEHAVIOUR
//  Reset (areset_n=0 at posedge): sda_oe=0, wr_en=0, rd_strobe=0, busy=0, pointer=0,
//   wr_addr=0, wr_data=0, state=IDLE, synchronisers loaded with 1.
//  Sync: scl_s/sda_s = SYNC_STAGES-FF sync; one extra reg for edge detect. Events are
//   evaluated on synced values: scl_rise, scl_fall;
//   START = sda_s falls while scl_s=1; STOP = sda_s rises while scl_s=1.
//  START (incl. repeated START) from any state -> ADDR, bit count 0, sda_oe=0, busy=1.
//   STOP from any state -> IDLE, sda_oe=0, busy=0. START/STOP take priority over bit events
//   in the same cycle.
//  Bits are sampled on scl_rise, MSB first. SDA changes by the target occur only on scl_fall.
//  States:
//   IDLE: wait for START.
//   ADDR: 8 bits. On the 8th scl_fall: if addr[7:1]==SLAVE_ADDR -> ACK_A with sda_oe=1;
//     otherwise -> IGNORE (sda_oe stays 0).
//   ACK_A: on the next scl_fall, release SDA. If R/W=0 -> REG.
//     If R/W=1 -> fetch, latch rd_data, pulse rd_strobe, drive bit7 -> TX.
//   REG: 8 bits -> pointer; ACK on 8th scl_fall -> ACK_R -> WDATA.
//   WDATA: 8 bits. On the 8th scl_rise+1 clk: wr_en=1 for 1 clk, wr_addr=pointer,
//     wr_data=byte. ACK, then pointer+1 (8-bit wrap 8'hFF->8'h00), remain in WDATA.
//   TX: shift out 8 bits (sda_oe = ~bit). After the 8th scl_fall release SDA -> ACK_M.
//   ACK_M: sample on scl_rise. If 0 (ACK): pointer+1, next fetch at scl_fall. If 1 (NACK)
//     -> IGNORE.
//   IGNORE: sda_oe=0; wait for START/STOP.
//  Fetch: rd_addr=pointer is valid >=1 clk before rd_data is latched. Reads start at the
//   pointer left by the last REG phase or write.
//  sda_oe is never asserted while scl_s=1 except when held across an ACK/data bit.
//  Reset mid-transfer returns to IDLE immediately and releases SDA on the same edge.
// TESTING
//  Write [0x20][0x05][0xA5] -> ACK on all 3; wr_en once, wr_addr=0x05, wr_data=0xA5; busy 0 after STOP.
//  Burst write 0x20,0xFE,0x11,0x22,0x33 -> writes (0xFE,0x11),(0xFF,0x22),(0x00,0x33): pointer wraps.
//  Write 0x20,0x10; rep-START 0x21; read 2 bytes (ACK,NACK) with rd_data=rd_addr^0x5A
//   -> SCL sees 0x4A, 0x4B; rd_strobe x2.
//  Address 0x22 (addr 0x11) -> no ACK (SDA high on 9th clock), no wr_en, sda_oe=0 until STOP.
//  START, 4 address bits, STOP, then valid write -> first frame aborted cleanly, second frame written.
//  areset_n low during ACK of data byte -> sda_oe=0 next posedge, busy=0, no wr_en issued.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target responder: oversampled SCL/SDA, START/STOP decode, register write/read
// with an auto-incrementing 8-bit pointer and open-drain SDA drive via sda_oe.
module i2c_target #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h10,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       scl_di,
  input  logic       sda_di,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       rd_strobe,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A, REG, ACK_R, WDATA, ACK_W, TX, ACK_M, FETCH, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_p0, sda_sync_p0;
  logic scl_s, sda_s, scl_p1, sda_p1;
  logic scl_rise, scl_fall, start_ev, stop_ev;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sh, sh_n;
  logic [7:0] ptr, ptr_n;
  logic [7:0] wr_addr_n, wr_data_n;
  logic       sda_oe_n, busy_n, wr_en_n, rd_strobe_n;

  // Stage p0: synchronisers, p1: one-cycle delay for edge detection
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      scl_sync_p0 <= '1;
      sda_sync_p0 <= '1;
      scl_p1      <= 1'b1;
      sda_p1      <= 1'b1;
    end else begin
      scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], scl_di};
      sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], sda_di};
      scl_p1      <= scl_s;
      sda_p1      <= sda_s;
    end
  end

  assign scl_s    = scl_sync_p0[SYNC_STAGES-1];
  assign sda_s    = sda_sync_p0[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_p1;
  assign scl_fall = ~scl_s & scl_p1;
  assign start_ev = scl_s & sda_p1 & ~sda_s;
  assign stop_ev  = scl_s & ~sda_p1 & sda_s;
  assign rd_addr  = ptr;

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_strobe <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ptr       <= ptr_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      wr_en     <= wr_en_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      rd_strobe <= rd_strobe_n;
    end
  end

  // Shared RX/TX shifter carries no control meaning, so it is left out of reset
  always_ff @(posedge clk) begin
    sh <= sh_n;
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sh_n        = sh;
    ptr_n       = ptr;
    sda_oe_n    = sda_oe;
    busy_n      = busy;
    wr_en_n     = 1'b0;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    rd_strobe_n = 1'b0;
    if (stop_ev) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_ev) begin
      state_n  = ADDR;
      cnt_n    = '0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b1;
    end else begin
      case (state)
        ADDR, REG, WDATA: begin
          if (scl_rise && cnt != 4'd8) begin
            sh_n  = {sh[6:0], sda_s};
            cnt_n = cnt + 4'd1;
            if (state == WDATA && cnt == 4'd7) begin
              wr_en_n   = 1'b1;
              wr_addr_n = ptr;
              wr_data_n = {sh[6:0], sda_s};
            end
          end else if (scl_fall && cnt == 4'd8) begin
            if (state == ADDR) begin
              if (sh[7:1] == SLAVE_ADDR) begin
                state_n  = ACK_A;
                sda_oe_n = 1'b1;
              end else begin
                state_n = IGNORE;
              end
            end else if (state == REG) begin
              ptr_n    = sh;
              sda_oe_n = 1'b1;
              state_n  = ACK_R;
            end else begin
              sda_oe_n = 1'b1;
              state_n  = ACK_W;
            end
          end
        end
        // sh[0] still holds the R/W bit of the address byte while in ACK_A
        ACK_A, FETCH: begin
          if (scl_fall) begin
            if (state == FETCH || sh[0]) begin
              sh_n        = rd_data;
              rd_strobe_n = 1'b1;
              sda_oe_n    = ~rd_data[7];
              cnt_n       = 4'd1;
              state_n     = TX;
            end else begin
              sda_oe_n = 1'b0;
              cnt_n    = '0;
              state_n  = REG;
            end
          end
        end
        ACK_R, ACK_W: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            cnt_n    = '0;
            state_n  = WDATA;
            if (state == ACK_W) ptr_n = ptr + 8'd1;
          end
        end
        TX: begin
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_oe_n = 1'b0;
              state_n  = ACK_M;
            end else begin
              sda_oe_n = ~sh[6];
              sh_n     = {sh[6:0], 1'b0};
              cnt_n    = cnt + 4'd1;
            end
          end
        end
        ACK_M: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_n   = ptr + 8'd1;
              state_n = FETCH;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        IGNORE: sda_oe_n = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master on an open-drain bus, reference pointer model.
module tb_i2c_target;

  localparam int Q = 6;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       areset_n;
  logic       scl, sda_m;
  logic       sda_oe, wr_en, rd_strobe, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data, rd_key;
  wire        sda_bus = sda_m & ~sda_oe;

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int oe_cnt = 0;
  logic [7:0] wq_a[$];
  logic [7:0] wq_d[$];
  logic [7:0] txq[$];

  assign rd_data = rd_addr ^ rd_key;

  i2c_target #(.SLAVE_ADDR(7'h10), .SYNC_STAGES(2)) dut (
    .clk(clk), .areset_n(areset_n), .scl_di(scl), .sda_di(sda_bus), .sda_oe(sda_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_strobe(rd_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_a.push_back(wr_addr);
      wq_d.push_back(wr_data);
    end
    if (rd_strobe) rd_cnt++;
    if (sda_oe) oe_cnt++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, required summary before limit");
    $fatal(1, "watchdog");
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl = 1'b1;   wq();
    sda_m = 1'b0; wq();
    scl = 1'b0;   wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl = 1'b1;   wq();
    sda_m = 1'b1; wq(); wq();
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; wq();
    scl = 1'b1; wq(); wq();
    scl = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    sda_m = 1'b1; wq();
    scl = 1'b1;   wq();
    ack = sda_bus; wq();
    scl = 1'b0;   wq();
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wq();
      scl = 1'b1;   wq();
      b[i] = sda_bus; wq();
      scl = 1'b0;   wq();
    end
    put_bit(nack);
  endtask

  // START followed by every byte in txq; counts bytes the target did not ACK
  task automatic send_txq(output int nacks);
    logic a;
    nacks = 0;
    i2c_start();
    foreach (txq[i]) begin
      send_byte(txq[i], a);
      if (a) nacks++;
    end
  endtask

  task automatic test_reset();
    areset_n = 1'b0; scl = 1'b1; sda_m = 1'b1; rd_key = 8'h00;
    repeat (4) @(negedge clk);
    areset_n = 1'b1;
    wq();
    n_cmp += 7;
    if (sda_oe !== 1'b0)   begin n_err++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    if (wr_en !== 1'b0)    begin n_err++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    if (rd_strobe !== 1'b0) begin n_err++; $display("FAIL reset_rd_strobe: got %b want 0", rd_strobe); end
    if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (rd_addr !== 8'h00) begin n_err++; $display("FAIL reset_rd_addr: got %h want 00", rd_addr); end
    if (wr_addr !== 8'h00) begin n_err++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
    if (wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
  endtask

  task automatic test_write_basic();
    int wb, nk, nw;
    wb = wq_a.size();
    txq = '{8'h20, 8'h05, 8'hA5};
    send_txq(nk);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy_mid: got %b want 1", busy); end
    i2c_stop();
    nw = wq_a.size() - wb;
    n_cmp += 3;
    if (nk != 0) begin n_err++; $display("FAIL wr_acks: got %0d nacks want 0", nk); end
    if (nw != 1) begin n_err++; $display("FAIL wr_count: got %0d want 1", nw); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_end: got %b want 0", busy); end
    if (nw >= 1) begin
      n_cmp++;
      if (wq_a[wb] !== 8'h05 || wq_d[wb] !== 8'hA5) begin
        n_err++; $display("FAIL wr_entry: got %h/%h want 05/a5", wq_a[wb], wq_d[wb]);
      end
    end
  endtask

  task automatic test_burst_wrap();
    int wb, nk, nw;
    logic [7:0] ea[3];
    logic [7:0] ed[3];
    ea = '{8'hFE, 8'hFF, 8'h00};
    ed = '{8'h11, 8'h22, 8'h33};
    wb = wq_a.size();
    txq = '{8'h20, 8'hFE, 8'h11, 8'h22, 8'h33};
    send_txq(nk);
    i2c_stop();
    nw = wq_a.size() - wb;
    n_cmp += 2;
    if (nk != 0) begin n_err++; $display("FAIL burst_acks: got %0d nacks want 0", nk); end
    if (nw != 3) begin n_err++; $display("FAIL burst_count: got %0d want 3", nw); end
    for (int i = 0; i < 3 && i < nw; i++) begin
      n_cmp++;
      if (wq_a[wb+i] !== ea[i] || wq_d[wb+i] !== ed[i]) begin
        n_err++;
        $display("FAIL burst_entry%0d: got %h/%h want %h/%h", i, wq_a[wb+i], wq_d[wb+i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_read();
    int wb, rb, nk;
    logic a;
    logic [7:0] b0, b1;
    rd_key = 8'h5A;
    wb = wq_a.size(); rb = rd_cnt;
    txq = '{8'h20, 8'h10};
    send_txq(nk);
    i2c_start();
    send_byte(8'h21, a);
    recv_byte(1'b0, b0);
    recv_byte(1'b1, b1);
    i2c_stop();
    n_cmp += 6;
    if (nk != 0 || a !== 1'b0) begin n_err++; $display("FAIL rd_acks: got %0d/%b want 0/0", nk, a); end
    if (b0 !== 8'h4A) begin n_err++; $display("FAIL rd_byte0: got %h want 4a", b0); end
    if (b1 !== 8'h4B) begin n_err++; $display("FAIL rd_byte1: got %h want 4b", b1); end
    if (rd_cnt - rb != 2) begin n_err++; $display("FAIL rd_strobes: got %0d want 2", rd_cnt - rb); end
    if (wq_a.size() != wb) begin n_err++; $display("FAIL rd_no_write: got %0d writes want 0", wq_a.size() - wb); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_wrong_addr();
    int wb, ob;
    logic a, a1;
    wb = wq_a.size(); ob = oe_cnt;
    i2c_start();
    send_byte(8'h22, a);
    send_byte(8'h05, a1);
    send_byte(8'hA5, a1);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL nack_busy_mid: got %b want 1", busy); end
    i2c_stop();
    n_cmp += 3;
    if (a !== 1'b1) begin n_err++; $display("FAIL nack_addr_ack: got %b want 1", a); end
    if (wq_a.size() != wb) begin n_err++; $display("FAIL nack_writes: got %0d want 0", wq_a.size() - wb); end
    if (oe_cnt != ob) begin n_err++; $display("FAIL nack_sda_oe: got %0d cycles driven want 0", oe_cnt - ob); end
  endtask

  task automatic test_abort();
    int wb, nk, nw;
    wb = wq_a.size();
    i2c_start();
    put_bit(1'b0); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    i2c_stop();
    n_cmp += 2;
    if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    if (wq_a.size() != wb) begin n_err++; $display("FAIL abort_writes: got %0d want 0", wq_a.size() - wb); end
    txq = '{8'h20, 8'h3C, 8'h77};
    send_txq(nk);
    i2c_stop();
    nw = wq_a.size() - wb;
    n_cmp += 2;
    if (nk != 0 || nw != 1) begin n_err++; $display("FAIL abort_second: got %0d nacks %0d writes want 0/1", nk, nw); end
    if (nw >= 1 && (wq_a[wb] !== 8'h3C || wq_d[wb] !== 8'h77)) begin
      n_err++; $display("FAIL abort_entry: got %h/%h want 3c/77", wq_a[wb], wq_d[wb]);
    end
  endtask

  // Reference: writes land at reg, reg+1, ... (mod 256); a following bare read starts at
  // the byte after the last write and the pointer advances only on master ACK.
  task automatic test_random();
    logic [7:0] mptr, r, b;
    logic a;
    int n, m, wb, rb, nk, nw;
    for (int it = 0; it < 4; it++) begin
      r = 8'($urandom);
      n = $urandom_range(1, 4);
      txq = '{8'h20, r};
      for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
      wb = wq_a.size();
      send_txq(nk);
      i2c_stop();
      nw = wq_a.size() - wb;
      n_cmp += 2;
      if (nk != 0) begin n_err++; $display("FAIL rnd%0d_acks: got %0d nacks want 0", it, nk); end
      if (nw != n) begin n_err++; $display("FAIL rnd%0d_count: got %0d want %0d", it, nw, n); end
      for (int i = 0; i < n && i < nw; i++) begin
        n_cmp++;
        if (wq_a[wb+i] !== 8'(r + 8'(i)) || wq_d[wb+i] !== txq[i+2]) begin
          n_err++;
          $display("FAIL rnd%0d_wr%0d: got %h/%h want %h/%h", it, i, wq_a[wb+i], wq_d[wb+i], 8'(r + 8'(i)), txq[i+2]);
        end
      end
      mptr = 8'(r + 8'(n));
      rd_key = 8'($urandom);
      m = $urandom_range(1, 3);
      rb = rd_cnt;
      i2c_start();
      send_byte(8'h21, a);
      n_cmp++;
      if (a !== 1'b0) begin n_err++; $display("FAIL rnd%0d_rd_ack: got %b want 0", it, a); end
      for (int j = 0; j < m; j++) begin
        recv_byte(j == m - 1, b);
        n_cmp++;
        if (b !== (8'(mptr + 8'(j)) ^ rd_key)) begin
          n_err++; $display("FAIL rnd%0d_rd%0d: got %h want %h", it, j, b, 8'(mptr + 8'(j)) ^ rd_key);
        end
      end
      i2c_stop();
      n_cmp++;
      if (rd_cnt - rb != m) begin n_err++; $display("FAIL rnd%0d_strobes: got %0d want %0d", it, rd_cnt - rb, m); end
    end
  endtask

  task automatic test_reset_mid();
    int nk, wb;
    txq = '{8'h20, 8'h40};
    send_txq(nk);
    for (int i = 7; i >= 0; i--) put_bit(1'(8'h99 >> i));
    sda_m = 1'b1; wq();
    scl = 1'b1;   wq();
    n_cmp++;
    if (sda_oe !== 1'b1) begin n_err++; $display("FAIL rstmid_ack_driven: got %b want 1", sda_oe); end
    wb = wq_a.size();
    areset_n = 1'b0;
    @(posedge clk); #1;
    n_cmp += 2;
    if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rstmid_sda_oe: got %b want 0", sda_oe); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    areset_n = 1'b1;
    scl = 1'b0; wq();
    i2c_stop();
    n_cmp += 2;
    if (wq_a.size() != wb) begin n_err++; $display("FAIL rstmid_writes: got %0d want 0", wq_a.size() - wb); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy_end: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_burst_wrap();
    test_read();
    test_wrong_addr();
    test_abort();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
